// File: rtl/period_capture.sv
// Measures cycles between rising edges of the counter's zero flag and queues each period in a show-ahead FIFO.
// Define PERIOD_CAPTURE_MINMAX_EN to track min/max over all captured periods; otherwise those ports are tied to 0.
module period_capture #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     zero,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [WIDTH-1:0]         min_period,
  output logic [WIDTH-1:0]         max_period
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t            state, state_nxt;
  logic              zero_q;
  logic              rise;
  logic [WIDTH-1:0]  timer, timer_nxt;
  logic              push, pop, accept;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;

  assign rise = zero & ~zero_q;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    push      = 1'b0;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (rise) begin
          state_nxt = MEASURE;
          timer_nxt = WIDTH'(1);
        end
      end
      MEASURE: begin
        if (rise) begin
          push      = 1'b1;
          timer_nxt = WIDTH'(1);
        end else if (timer != '1) begin
          timer_nxt = timer + WIDTH'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A push into a full FIFO is only accepted when a pop frees the head slot in the same cycle.
  assign pop    = rd_en & (level != '0);
  assign accept = push & ((level != LW'(DEPTH)) | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      zero_q   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      zero_q <= zero;
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push & ~accept) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) mem[wr_ptr] <= timer;
  end

  assign valid   = (level != '0);
  assign full    = (level == LW'(DEPTH));
  assign rd_data = valid ? mem[rd_ptr] : '0;

`ifdef PERIOD_CAPTURE_MINMAX_EN
  logic seen;

  // Dropped pushes still count toward the extremes.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen       <= 1'b0;
      min_period <= '0;
      max_period <= '0;
    end else if (push) begin
      seen <= 1'b1;
      if (!seen || timer < min_period) min_period <= timer;
      if (!seen || timer > max_period) max_period <= timer;
    end
  end
`else
  assign min_period = '0;
  assign max_period = '0;
`endif

endmodule

// File: doc/period_capture.md
PERIOD_CAPTURE -- requirements
Module: period_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries, power of two, range 2..16.
REQ-002 SHALL have parameter WIDTH, default 8, bit width of period values and timer.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port zero  in  1  level from the down counter, high while its count equals 0.
REQ-006 SHALL have port rd_en  in  1  pop request for the head entry.
REQ-007 SHALL have port rd_data  out  WIDTH  head entry, show-ahead; 0 when empty.
REQ-008 SHALL have port valid  out  1  FIFO not empty.
REQ-009 SHALL have port full  out  1  FIFO holds DEPTH entries.
REQ-010 SHALL have port level  out  log2(DEPTH)+1  current entry count.
REQ-011 SHALL have port overflow  out  1  sticky; a push was dropped.
REQ-012 SHALL have ports min_period and max_period  out  WIDTH  extremes of captured periods (see REQ-030).

Function
REQ-013 SHALL register zero into zero_q each cycle; rise = zero & ~zero_q.
REQ-014 SHALL implement FSM states IDLE and MEASURE.
REQ-015 In IDLE, SHALL hold timer at 0; on rise, SHALL go to MEASURE with timer <= 1 and push nothing.
REQ-016 In MEASURE without rise, SHALL set timer <= timer+1, saturating at 2^WIDTH-1.
REQ-017 In MEASURE with rise, SHALL push the current timer value and set timer <= 1.
- Rises at cycles t0 and t1 yield pushed value t1-t0, saturated.
REQ-018 SHALL remain in MEASURE until rst; there is no other exit.
REQ-019 rd_en with valid=0 SHALL be ignored with no state change.
REQ-020 A push SHALL become visible on rd_data/valid in the cycle after the push edge (1-cycle latency).
REQ-021 Push and pop in the same cycle with level=DEPTH SHALL both succeed; level unchanged.
REQ-022 Push and pop in the same cycle with level=0 SHALL perform the push only; pop ignored.
REQ-023 Push with level=DEPTH and no pop SHALL drop the value, set overflow, and leave contents unchanged.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; level SHALL equal the number of stored entries at all times.
REQ-025 full SHALL be (level==DEPTH); valid SHALL be (level!=0); both SHALL be driven from registered state.

Reset
REQ-026 With rst high at a clock edge, the block SHALL enter IDLE with timer=0, zero_q=0, pointers=0, level=0, overflow=0.
REQ-027 Outputs after reset SHALL be rd_data=0, valid=0, full=0, min_period=0, max_period=0.
REQ-028 rst mid-measurement SHALL discard the partial period and all FIFO contents; no push occurs in that cycle.
REQ-029 After reset, a zero held high SHALL count as a rise on the first non-reset cycle, because zero_q=0.

Configuration
REQ-030 Macro PERIOD_CAPTURE_MINMAX_EN SHALL control min/max tracking.
- Defined: each push, including a dropped one, updates min_period/max_period; the first push after reset loads both.
- Undefined: ports exist, tied 0, and no tracking logic is synthesized.

Verification
REQ-031 SHALL cover: zero pulses 1 cycle every 4 cycles, 3 pulses -> 2 entries, each 4; level=2; min=max=4 with macro.
REQ-032 SHALL cover: 6 periods of 5 cycles, no rd_en -> level=4, full=1, overflow=1, rd_data=5; pop all gives four 5s.
REQ-033 SHALL cover: full FIFO, rise coincident with rd_en -> level stays 4, new value at tail, overflow stays 0.
REQ-034 SHALL cover: rises 300 cycles apart with WIDTH=8 -> pushed value 255.
REQ-035 SHALL cover: rst asserted 2 cycles after the first rise, then periods of 3 -> first entry 3 counted from the first post-reset rise; prior state gone.
REQ-036 SHALL cover: rd_en pulsed while empty -> level=0, valid=0, rd_data=0, no underflow.
